// File: rtl/twiddle_if.sv
// ---------------------------------------------------------------------------
// twiddle_if -- valid/ready twiddle stream from twiddle_gen to its consumer.
//
// Signals:
//   tw_valid  producer -> consumer  tw_data/tw_idx are valid
//   tw_ready  consumer -> producer  consumer accepts the current token
//   tw_data   producer -> consumer  twiddle value (DATA_W bits)
//   tw_idx    producer -> consumer  exponent of tw_data (LOG_N bits)
//
// Modports: master = twiddle_gen side, slave = consumer side.
// ---------------------------------------------------------------------------
interface twiddle_if #(
  parameter int DATA_W = 13,
  parameter int LOG_N  = 8
) ();
  logic              tw_valid;
  logic              tw_ready;
  logic [DATA_W-1:0] tw_data;
  logic [LOG_N-1:0]  tw_idx;

  modport master (output tw_valid, output tw_data, output tw_idx, input  tw_ready);
  modport slave  (input  tw_valid, input  tw_data, input  tw_idx, output tw_ready);
endinterface

// File: rtl/twiddle_gen.sv
// ---------------------------------------------------------------------------
// twiddle_gen -- streaming twiddle-factor source for the NTT datapath.
//
// On start, emits omega^0 .. omega^(count-1) mod q, one per valid/ready
// handshake. Each successive power comes from a DATA_W-cycle interleaved
// shift-add modular multiply of the previous power by omega, so there is a
// gap of exactly DATA_W cycles between tokens.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-low reset
//   start    in   one-cycle request, sampled only in IDLE
//   q        in   modulus (>= 2), latched at start
//   omega    in   root of unity (< q), latched at start
//   scale    in   first value (< q), TWIDDLE_SCALE_EN builds only
//   count    in   number of twiddles to emit, latched at start
//   busy     out  high in any state other than IDLE
//   done     out  one-cycle pulse after the last handshake
//   tw       twiddle_if.master: tw_valid / tw_ready / tw_data / tw_idx
//
// Build option: define TWIDDLE_SCALE_EN to add the scale port; the stream
// then becomes scale*omega^k mod q. Timing is identical in both builds.
// ---------------------------------------------------------------------------
module twiddle_gen #(
  parameter int DATA_W    = 13,
  parameter int RING_SIZE = 256,
  localparam int LOG_N    = $clog2(RING_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] omega,
`ifdef TWIDDLE_SCALE_EN
  input  logic [DATA_W-1:0] scale,
`endif
  input  logic [LOG_N-1:0]  count,
  output logic              busy,
  output logic              done,
  twiddle_if.master         tw
);

  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] omega_r;
  logic [LOG_N-1:0]  count_r;
  logic [DATA_W-1:0] acc;
  logic [BIT_W-1:0]  bit_cnt;

  logic [DATA_W:0]   dbl;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] first_val;

`ifdef TWIDDLE_SCALE_EN
  assign first_val = scale;
`else
  assign first_val = DATA_W'(1);
`endif

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  // One step of the MSB-first interleaved multiply: acc*2 (+ tw_data) mod q.
  // Both operands are < q, so each partial result is < 2q and a single
  // conditional subtraction after each add restores it to [0, q).
  // NOTE: every variable in an always_comb is assigned before any branch,
  // so no path leaves it holding its old value (which would infer a latch).
  always_comb begin
    dbl = {acc, 1'b0};
    if (dbl >= {1'b0, q_r}) dbl = dbl - {1'b0, q_r};
    sum = dbl;
    if (omega_r[bit_cnt]) sum = dbl + {1'b0, tw.tw_data};
    if (sum >= {1'b0, q_r}) sum = sum - {1'b0, q_r};
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      q_r         <= '0;
      omega_r     <= '0;
      count_r     <= '0;
      acc         <= '0;
      bit_cnt     <= '0;
      tw.tw_valid <= 1'b0;
      tw.tw_data  <= '0;
      tw.tw_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_r     <= q;
            omega_r <= omega;
            count_r <= count;
            if (count != '0) begin
              tw.tw_data  <= first_val;
              tw.tw_idx   <= '0;
              tw.tw_valid <= 1'b1;
              state       <= EMIT;
            end else begin
              state <= FIN;
            end
          end
        end

        EMIT: begin
          if (tw.tw_ready) begin
            tw.tw_valid <= 1'b0;
            if (tw.tw_idx == count_r - LOG_N'(1)) begin
              state <= FIN;
            end else begin
              acc     <= '0;
              bit_cnt <= BIT_W'(DATA_W - 1);
              state   <= MUL;
            end
          end
        end

        MUL: begin
          acc     <= sum[DATA_W-1:0];
          bit_cnt <= bit_cnt - BIT_W'(1);
          if (bit_cnt == '0) begin
            tw.tw_data  <= sum[DATA_W-1:0];
            tw.tw_idx   <= tw.tw_idx + LOG_N'(1);
            tw.tw_valid <= 1'b1;
            state       <= EMIT;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// ---------------------------------------------------------------------------
// tb_twiddle_gen -- self-checking bench for twiddle_gen.
// Table of directed runs with hand-computed twiddle sequences, plus a
// hand-written mid-MUL reset sequence. Inputs change and outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_twiddle_gen;
  localparam int DATA_W    = 13;
  localparam int RING_SIZE = 256;
  localparam int LOG_N     = 8;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] q     = '0;
  logic [DATA_W-1:0] omega = '0;
  logic [DATA_W-1:0] scale = 13'd1;
  logic [LOG_N-1:0]  count = '0;
  logic              busy;
  logic              done;

  twiddle_if #(.DATA_W(DATA_W), .LOG_N(LOG_N)) tw ();

  twiddle_gen #(.DATA_W(DATA_W), .RING_SIZE(RING_SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .q     (q),
    .omega (omega),
`ifdef TWIDDLE_SCALE_EN
    .scale (scale),
`endif
    .count (count),
    .busy  (busy),
    .done  (done),
    .tw    (tw.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] omega;
    logic [DATA_W-1:0] scale;
    logic [LOG_N-1:0]  count;
    int                stall;       // cycles tw_ready is held low at each token
    bit                busy_start;  // pulse start during the 2nd token's MUL
    logic [5:0][DATA_W-1:0] exp;
  } vec_t;

  function automatic vec_t mk(input string tag, input int qq, input int ww, input int ss,
                              input int cc, input int stall, input bit bs,
                              input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int e5);
    vec_t v;
    v.tag = tag; v.q = DATA_W'(qq); v.omega = DATA_W'(ww); v.scale = DATA_W'(ss);
    v.count = LOG_N'(cc); v.stall = stall; v.busy_start = bs;
    v.exp[0] = DATA_W'(e0); v.exp[1] = DATA_W'(e1); v.exp[2] = DATA_W'(e2);
    v.exp[3] = DATA_W'(e3); v.exp[4] = DATA_W'(e4); v.exp[5] = DATA_W'(e5);
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int gap;
    int extra;
    q = v.q; omega = v.omega; scale = v.scale; count = v.count;
    tw.tw_ready = (v.stall == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < int'(v.count); k++) begin
      gap = 0;
      while (!tw.tw_valid && gap < 40) begin
        if (v.busy_start && k == 1 && gap == 3) begin
          start = 1'b1; q = 13'd11; omega = 13'd5; count = 8'd1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        gap++;
      end
      start = 1'b0;
      check({v.tag, " gap"}, gap, (k == 0) ? 0 : DATA_W);
      check({v.tag, " busy"}, busy, 1);
      for (int s = 0; s < v.stall; s++) begin
        check({v.tag, " stall valid"}, tw.tw_valid, 1);
        check({v.tag, " stall data"}, tw.tw_data, v.exp[k]);
        check({v.tag, " stall idx"}, tw.tw_idx, k);
        @(negedge clk);
      end
      check({v.tag, " data"}, tw.tw_data, v.exp[k]);
      check({v.tag, " idx"}, tw.tw_idx, k);
      tw.tw_ready = 1'b1;
      @(negedge clk);
      tw.tw_ready = (v.stall == 0);
    end
    check({v.tag, " done pulse"}, done, 1);
    check({v.tag, " valid after last"}, tw.tw_valid, 0);
    @(negedge clk);
    check({v.tag, " done clear"}, done, 0);
    check({v.tag, " busy clear"}, busy, 0);
    extra = 0;
    repeat (15) begin
      if (tw.tw_valid || done) extra++;
      @(negedge clk);
    end
    check({v.tag, " no extra tokens"}, extra, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int wait_cnt;
    vecs.push_back(mk("q7 w3 c6",      7,    3,    1, 6, 0, 0, 1, 3,    2, 6, 4, 5));
    vecs.push_back(mk("q7681 w2 c4",   7681, 2,    1, 4, 0, 0, 1, 2,    4, 8, 0, 0));
    vecs.push_back(mk("q7681 w-1 c3",  7681, 7680, 1, 3, 0, 0, 1, 7680, 1, 0, 0, 0));
    vecs.push_back(mk("stall q7 w3",   7,    3,    1, 3, 5, 0, 1, 3,    2, 0, 0, 0));
    vecs.push_back(mk("count0",        7,    3,    1, 0, 0, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(mk("start busy",    7,    3,    1, 4, 0, 1, 1, 3,    2, 6, 0, 0));
`ifdef TWIDDLE_SCALE_EN
    vecs.push_back(mk("scale5 q7 w3",  7,    3,    5, 3, 0, 0, 5, 1,    3, 0, 0, 0));
`endif

    tw.tw_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset valid", tw.tw_valid, 0);
    check("reset data",  tw.tw_data, 0);
    check("reset idx",   tw.tw_idx, 0);
    check("reset busy",  busy, 0);
    check("reset done",  done, 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted during the MUL that computes the 2nd token's successor.
    q = 13'd7; omega = 13'd3; count = 8'd3; tw.tw_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (!(tw.tw_valid && tw.tw_idx == 8'd1) && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("mid reset reach idx1", wait_cnt < 40, 1);
    repeat (3) @(negedge clk);
    check("mid reset in MUL", tw.tw_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid reset valid", tw.tw_valid, 0);
    check("mid reset data",  tw.tw_data, 0);
    check("mid reset idx",   tw.tw_idx, 0);
    check("mid reset busy",  busy, 0);
    check("mid reset done",  done, 0);
    reset = 1'b1;
    @(negedge clk);
    run_vec(mk("after reset", 7, 3, 1, 2, 0, 0, 1, 3, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
